// File: rtl/demux_out_buffer_2ch.sv
// demux_out_buffer_2ch: buffered back end of the 1-to-2 demux.
// Each accepted word is steered by Sel into one of two show-ahead FIFOs.
// Each FIFO drives its own valid/ready consumer port, so either consumer can
// stall without losing data or blocking the other channel.
// Optional feature: define DEMUX_OUT_BUFFER_STATS_EN to add saturating 16-bit
// per-channel push counters (Y0_count / Y1_count).

// One channel: show-ahead FIFO with a level counter and an optional push counter.
module demux_out_buffer_2ch_chan #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,   // already qualified by In_ready at the top
    input  logic [W-1:0]  push_data,
    input  logic          pop_rdy,    // raw consumer ready; ignored while empty
    output logic          full,
    output logic          valid,
    output logic [W-1:0]  head,
    output logic [LW-1:0] level
`ifdef DEMUX_OUT_BUFFER_STATS_EN
    ,
    output logic [15:0]   count
`endif
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q;
    logic          do_pop;

    // A pop only happens when there is something to hand out.
    assign do_pop = pop_rdy & (level_q != '0);

    // Storage is deliberately left out of reset; the level gates visibility.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally (DEPTH is a power of 2); level disambiguates full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({push_vld, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign full  = (level_q == LW'(DEPTH));
    assign valid = (level_q != '0);
    assign head  = valid ? mem[rd_ptr] : '0;
    assign level = level_q;

`ifdef DEMUX_OUT_BUFFER_STATS_EN
    logic [15:0] count_q;

    // Saturating count of words pushed into this channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              count_q <= '0;
        else if (push_vld && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end

    assign count = count_q;
`endif

endmodule

// Top: input steering, ready generation and the two channel instances.
module demux_out_buffer_2ch #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  In_data,
    input  logic          In_valid,
    input  logic          Sel,
    output logic          In_ready,
    output logic [W-1:0]  Y0_data,
    output logic          Y0_valid,
    input  logic          Y0_ready,
    output logic [W-1:0]  Y1_data,
    output logic          Y1_valid,
    input  logic          Y1_ready,
    output logic [LW-1:0] Y0_level,
    output logic [LW-1:0] Y1_level
`ifdef DEMUX_OUT_BUFFER_STATS_EN
    ,
    output logic [15:0]   Y0_count,
    output logic [15:0]   Y1_count
`endif
);
    localparam int NUM_CH = 2;

    typedef struct packed {
        logic         vld;
        logic [W-1:0] data;
    } push_req_t;

    push_req_t [NUM_CH-1:0]         push_req;
    logic [NUM_CH-1:0]              pop_rdy;
    logic [NUM_CH-1:0]              ch_full;
    logic [NUM_CH-1:0]              ch_valid;
    logic [NUM_CH-1:0][W-1:0]       ch_data;
    logic [NUM_CH-1:0][LW-1:0]      ch_level;
`ifdef DEMUX_OUT_BUFFER_STATS_EN
    logic [NUM_CH-1:0][15:0]        ch_count;
`endif
    logic                           run_q;
    logic                           accept;

    // Holds In_ready low through reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // Ready looks only at the selected channel's registered full flag:
    // a full channel stays closed even if its consumer pops this cycle.
    assign In_ready = run_q & ~ch_full[Sel];
    assign accept   = In_valid & In_ready;
    assign pop_rdy  = {Y1_ready, Y0_ready};

    // Steer the accepted word; the unselected channel sees no push.
    always_comb begin
        push_req = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            push_req[ch].vld  = accept & (Sel == 1'(ch));
            push_req[ch].data = In_data;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        demux_out_buffer_2ch_chan #(
            .W     (W),
            .DEPTH (DEPTH),
            .LW    (LW)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .push_vld  (push_req[g].vld),
            .push_data (push_req[g].data),
            .pop_rdy   (pop_rdy[g]),
            .full      (ch_full[g]),
            .valid     (ch_valid[g]),
            .head      (ch_data[g]),
            .level     (ch_level[g])
`ifdef DEMUX_OUT_BUFFER_STATS_EN
            ,
            .count     (ch_count[g])
`endif
        );
    end

    assign Y0_data  = ch_data[0];
    assign Y0_valid = ch_valid[0];
    assign Y0_level = ch_level[0];
    assign Y1_data  = ch_data[1];
    assign Y1_valid = ch_valid[1];
    assign Y1_level = ch_level[1];
`ifdef DEMUX_OUT_BUFFER_STATS_EN
    assign Y0_count = ch_count[0];
    assign Y1_count = ch_count[1];
`endif

endmodule

// File: doc/demux_out_buffer_2ch.md
Name: demux_out_buffer_2ch

Overview:
- Downstream stage of the 1-to-2 demux.
- Takes a W-bit stream with a 1-bit select and steers each accepted word into one of two per-channel FIFOs.
- Presents each channel to its consumer with a valid/ready handshake.
- Adds buffering and backpressure that the combinational demux lacks, so either consumer can stall without losing data.

Parameters:
W, 8, data width in bits
DEPTH, 4, entries per channel FIFO; power of 2, minimum 2
LW, $clog2(DEPTH+1), width of level outputs (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
In_data  input  W  input word
In_valid  input  1  upstream word available
Sel  input  1  destination: 0 -> channel 0, 1 -> channel 1
In_ready  output  1  block can accept a word for the channel currently selected
Y0_data  output  W  channel 0 head word
Y0_valid  output  1  channel 0 non-empty
Y0_ready  input  1  channel 0 consumer accepts
Y1_data  output  W  channel 1 head word
Y1_valid  output  1  channel 1 non-empty
Y1_ready  input  1  channel 1 consumer accepts
Y0_level  output  LW  channel 0 occupancy
Y1_level  output  LW  channel 1 occupancy

Behaviour:
- Interface:
  - One clock domain.
  - Reset is asynchronous and active-low on rst_n.
  - Clock port is clk.
- Reset:
  - Read/write pointers, levels and all outputs go to 0 immediately on rst_n low.
  - In_ready=0 while rst_n low; In_ready=1 from the first cycle after release.
  - Storage array is not reset.
- Input acceptance:
  - In_ready = ~full[Sel], combinational from Sel and registered full flags only.
  - In_ready does not depend on In_valid or on Yn_ready.
  - Push to channel Sel when In_valid & In_ready at a rising edge.
  - The other channel is untouched.
- Output:
  - Show-ahead FIFO: Yn_valid = (level_n != 0); Yn_data = head entry when Yn_valid=1, else forced to 0.
  - Pop when Yn_valid & Yn_ready at a rising edge.
- Latency:
  - A word pushed at edge N drives Yn_valid/Yn_data from edge N onward, i.e. it is visible in cycle N+1.
  - No same-cycle bypass from In to Yn.
- Push and pop in the same cycle on one channel: level unchanged, both pointers advance.
- Full channel:
  - In_ready=0 while Sel points at it, even if its consumer pops in that cycle.
  - No ready pass-through; the word waits in upstream.
- Empty channel:
  - Yn_valid=0; Yn_ready is ignored.
  - The pointer does not move and the level does not underflow.
- Pointers:
  - Log2(DEPTH) bits, wrapping modulo DEPTH.
  - The level counter distinguishes full from empty.
- Sel changes while In_valid is held high:
  - Legal.
  - The destination is sampled only at the accepting edge.
- Channel independence:
  - A stalled channel never blocks the other.
  - Pushes to channel 1 proceed while channel 0 is full.
- Reset mid-operation: all buffered words are discarded; the block restarts empty.
- Order: words leave each channel in arrival order.

Optional Feature:
- Macro DEMUX_OUT_BUFFER_STATS_EN.
- When defined:
  - Adds outputs Y0_count and Y1_count, 16 bits each.
  - Each counts words pushed into its channel.
  - Saturates at 16'hFFFF.
  - Cleared by rst_n.
- When undefined: these ports and the counter logic do not exist.
- Datapath behaviour is identical either way.

Test Plan (W=8, DEPTH=4):
- Reset released, no traffic -> In_ready=1; Y0_valid=Y1_valid=0; both levels 0; Y0_data=Y1_data=0.
- Push 8'hA5 with Sel=0 at edge N, Y0_ready=0 -> Y0_valid=1, Y0_data=A5, Y0_level=1 after edge N; Y1_valid stays 0.
- With Y1_ready=0, push 8'h10, 11, 12, 13 with Sel=1, then offer 8'h14 -> Y1_level=4; In_ready=0 with Sel=1 and stays 0 while Y1_ready=1 pops in that cycle. Switching Sel=0 gives In_ready=1 and 8'h14 lands in channel 0. Channel 1 drains 10, 11, 12, 13 in order.
- Channel 0 holds 2 words; push and pop on channel 0 in the same cycle for 6 consecutive cycles -> level stays 2, order preserved, pointers wrap past DEPTH with no corruption.
- Mid-stream (Y0_level=3, Y1_level=2), assert rst_n low between clock edges -> levels, valids and In_ready go to 0 immediately. After release both channels are empty and the next push appears correctly.
- With DEMUX_OUT_BUFFER_STATS_EN, push 5 words to channel 0 and 2 to channel 1 -> Y0_count=5, Y1_count=2. Preloading to near-saturation by long traffic shows the counter holds at FFFF.
